pwm_multi_deadtime: RTL and testbench

Multi-channel PWM generator with complementary high/low outputs and dead-time insertion. It generalises the single-channel prescaled PWM in four ways: channel count, programmable period, shadowed (glitch-free) parameter updates, and per-transition dead time. All channels share one prescaler and one period counter, so they are phase-aligned. The block drives half-bridge gate drivers directly.

---
 rtl/pwm_multi_deadtime.sv | 123 ++++++++++++
 tb/tb_pwm_multi_deadtime.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_deadtime.sv
// pwm_multi_deadtime: phase-aligned multi-channel complementary PWM with shadowed settings and dead time.
// Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting; edge-aligned otherwise.
module pwm_multi_deadtime #(
  parameter int CH = 4,
  parameter int R = 8,
  parameter int TIMER_BITS = 8,
  parameter int DT_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic [R-1:0]          period,
  input  logic [CH*(R+1)-1:0]   duty,
  input  logic [DT_BITS-1:0]    deadtime,
  output logic [CH-1:0]         pwm_hi,
  output logic [CH-1:0]         pwm_lo,
  output logic                  period_start
);
  logic [TIMER_BITS-1:0] r_pcnt;
  logic [R-1:0]          r_cnt;
  logic [R-1:0]          r_per_sh;
  logic [CH*(R+1)-1:0]   r_duty_sh;
  logic [DT_BITS-1:0]    r_dt_sh;
  logic [CH-1:0]         r_raw;
  logic [CH-1:0]         r_raw_prev;
  logic [DT_BITS-1:0]    r_dtcnt [CH];
  logic                  w_tick;
  logic                  w_wrap;
  logic [R-1:0]          w_cnt_nxt;

  assign w_tick = enable && reset_n && (r_pcnt == FINAL_VALUE);

`ifdef PWM_CENTER_ALIGNED_EN
  logic r_down;
  logic w_down_nxt;
  // cnt==0 only occurs at the valley or on the first tick after enable
  assign w_wrap = w_tick && (r_cnt == '0);
  always_comb begin
    w_down_nxt = r_down;
    w_cnt_nxt  = r_cnt - R'(1);
    if (r_cnt == '0) begin
      w_down_nxt = 1'b0;
      w_cnt_nxt  = R'(r_per_sh != '0);
    end else if (!r_down && r_cnt >= r_per_sh) begin
      w_down_nxt = 1'b1;
    end else if (!r_down) begin
      w_cnt_nxt  = r_cnt + R'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_down <= 1'b0;
    else if (!enable) r_down <= 1'b0;
    else if (w_tick) r_down <= w_down_nxt;
  end
`else
  assign w_wrap    = w_tick && (r_cnt == r_per_sh);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + R'(1);
`endif

  assign period_start = w_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
      r_raw  <= '0;
    end else if (!enable) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
      r_raw  <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + TIMER_BITS'(1);
      if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        for (int i = 0; i < CH; i++)
          r_raw[i] <= {1'b0, r_cnt} < r_duty_sh[i*(R+1) +: R+1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_per_sh  <= '0;
      r_duty_sh <= '0;
      r_dt_sh   <= '0;
    end else if (!enable || w_wrap) begin
      r_per_sh  <= period;
      r_duty_sh <= duty;
      r_dt_sh   <= deadtime;
    end
  end

  // any raw edge forces both drives low and (re)starts the dead-time count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_prev <= '0;
      pwm_hi     <= '0;
      pwm_lo     <= '0;
      for (int i = 0; i < CH; i++) r_dtcnt[i] <= '0;
    end else begin
      r_raw_prev <= r_raw;
      for (int i = 0; i < CH; i++) begin
        if (!enable) begin
          r_dtcnt[i] <= deadtime;
          pwm_hi[i]  <= 1'b0;
          pwm_lo[i]  <= 1'b0;
        end else if (r_raw[i] != r_raw_prev[i]) begin
          r_dtcnt[i] <= r_dt_sh;
          pwm_hi[i]  <= 1'b0;
          pwm_lo[i]  <= 1'b0;
        end else if (r_dtcnt[i] != '0) begin
          r_dtcnt[i] <= r_dtcnt[i] - DT_BITS'(1);
          pwm_hi[i]  <= 1'b0;
          pwm_lo[i]  <= 1'b0;
        end else begin
          pwm_hi[i]  <= r_raw[i];
          pwm_lo[i]  <= ~r_raw[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_deadtime.sv
// tb_pwm_multi_deadtime: directed and randomized checks of pwm_multi_deadtime against a tick/period reference model.
module tb_pwm_multi_deadtime;
  localparam int CH = 4, R = 8, TB = 8, DB = 6;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [TB-1:0] fv = '0;
  logic [R-1:0] period = '0;
  logic [CH*(R+1)-1:0] duty = '0;
  logic [DB-1:0] deadtime = '0;
  logic [CH-1:0] pwm_hi, pwm_lo;
  logic period_start;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pwm_multi_deadtime #(.CH(CH), .R(R), .TIMER_BITS(TB), .DT_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .FINAL_VALUE(fv), .period(period),
    .duty(duty), .deadtime(deadtime), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start)
  );

  // reference: n = enabled clks, k = ticks since enable, lc = clk index of last raw event
  int e = 0, n = 0, k = 0, m_per = 0, m_dt = 0;
  int m_duty [CH] = '{default: 0};
  int lc [CH] = '{default: -1};
  bit m_raw [CH] = '{default: 1'b0};
  logic [CH-1:0] exp_hi = '0, exp_lo = '0;

  function automatic int cnt_now();
`ifdef PWM_CENTER_ALIGNED_EN
    int m;
    if (m_per == 0) return 0;
    m = k % (2 * m_per);
    return (m <= m_per) ? m : 2 * m_per - m;
`else
    return k % (m_per + 1);
`endif
  endfunction

  function automatic bit is_wrap(input int c);
`ifdef PWM_CENTER_ALIGNED_EN
    return c == 0;
`else
    return c == m_per;
`endif
  endfunction

  function automatic bit exp_ps();
    return enable && reset_n && (n % (int'(fv) + 1) == int'(fv)) && is_wrap(cnt_now());
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int c;
    bit tk, st, nr;
    if (!reset_n) begin
      e = 0; n = 0; k = 0; m_per = 0; m_dt = 0; exp_hi = '0; exp_lo = '0;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_raw[i] = 1'b0; lc[i] = -1; end
    end else begin
      e++;
      if (!enable) begin
        n = 0; k = 0; m_per = int'(period); m_dt = int'(deadtime);
        for (int i = 0; i < CH; i++) begin
          m_duty[i] = int'(duty[i*(R+1) +: R+1]);
          lc[i] = m_raw[i] ? e : e - 1;
          m_raw[i] = 1'b0; exp_hi[i] = 1'b0; exp_lo[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          st = (e - lc[i]) >= (m_dt + 2);
          exp_hi[i] = st && m_raw[i];
          exp_lo[i] = st && !m_raw[i];
        end
        tk = (n % (int'(fv) + 1)) == int'(fv);
        n++;
        if (tk) begin
          c = cnt_now();
          for (int i = 0; i < CH; i++) begin
            nr = c < m_duty[i];
            if (nr != m_raw[i]) lc[i] = e;
            m_raw[i] = nr;
          end
          if (is_wrap(c)) begin
            m_per = int'(period); m_dt = int'(deadtime);
            for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*(R+1) +: R+1]);
          end
          k++;
        end
      end
    end
  end

  task automatic set_duty(input int ch, input int v);
    logic [R:0] t;
    t = v[R:0];
    duty[ch*(R+1) +: R+1] = t;
  endtask

  task automatic setup(input int f, input int p, input int dt);
    @(negedge clk);
    enable = 1'b0; fv = f[TB-1:0]; period = p[R-1:0]; deadtime = dt[DB-1:0];
  endtask

  task automatic go;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset;
    enable = 1'b1; fv = '0; period = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo, period_start} !== '0) begin
      errors++; $display("FAIL reset_hold got %b want 0", {pwm_hi, pwm_lo, period_start});
    end
    enable = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo, period_start} !== '0) begin
      errors++; $display("FAIL reset_release got %b want 0", {pwm_hi, pwm_lo, period_start});
    end
  endtask

  task automatic test_deadtime;
    int nh = 0, nl = 0, np = 0;
    setup(0, 9, 2);
    set_duty(0, 5); set_duty(1, 5); set_duty(2, $urandom_range(0, 10)); set_duty(3, $urandom_range(0, 10));
    go();
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL deadtime cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
      if (j > 30) begin
        if (pwm_hi[0]) nh++;
        if (pwm_lo[0]) nl++;
        if (period_start) np++;
      end
    end
    checks++;
    if (nh != 6 || nl != 6 || np != 3) begin
      errors++; $display("FAIL deadtime_widths got hi=%0d lo=%0d ps=%0d want 6 6 3", nh, nl, np);
    end
  endtask

  task automatic test_duty_extremes;
    setup(0, 9, 1);
    set_duty(0, 0); set_duty(1, 10); set_duty(2, $urandom_range(0, 10)); set_duty(3, $urandom_range(0, 10));
    go();
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL extremes cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
      if (j >= 5) begin
        checks++;
        if ({pwm_hi[0], pwm_lo[0], pwm_hi[1], pwm_lo[1]} !== 4'b0110) begin
          errors++; $display("FAIL extremes_const cyc %0d got %b want 0110", j, {pwm_hi[0], pwm_lo[0], pwm_hi[1], pwm_lo[1]});
        end
      end
    end
  endtask

  task automatic test_shadow;
    int w = 0, ca = 0, cb = 0;
    setup(0, 9, 0);
    set_duty(0, 5);
    go();
    do begin @(negedge clk); w++; end while (period_start !== 1'b1 && w < 30);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL shadow_wait got ps=%b want 1 within 30 clk", period_start); end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL shadow cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
      if (pwm_hi[0]) begin if (j <= 10) ca++; else cb++; end
      if (j == 10 || j == 20) begin
        checks++;
        if (period_start !== 1'b1) begin errors++; $display("FAIL shadow_ps cyc %0d got %b want 1", j, period_start); end
      end
      if (j == 4) set_duty(0, 8);
    end
    checks++;
    if (ca != 4 || cb != 7) begin errors++; $display("FAIL shadow_widths got %0d/%0d want 4/7", ca, cb); end
  endtask

  task automatic test_prescaler;
    int nh = 0, nl = 0, np = 0;
    setup(3, 3, 0);
    set_duty(0, 2);
    go();
    for (int j = 1; j <= 84; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL prescaler cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
      if (j > 20) begin
        if (pwm_hi[0]) nh++;
        if (pwm_lo[0]) nl++;
        if (period_start) np++;
      end
    end
    checks++;
    if (nh != 28 || nl != 28 || np != 4) begin
      errors++; $display("FAIL prescaler_widths got hi=%0d lo=%0d ps=%0d want 28 28 4", nh, nl, np);
    end
  endtask

  task automatic test_enable;
    int first = -1;
    setup(0, 9, 2);
    set_duty(0, 5);
    go();
    repeat (25) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({pwm_hi, pwm_lo} !== '0) begin errors++; $display("FAIL enable_off got %b want 0", {pwm_hi, pwm_lo}); end
    deadtime = 6'd4; set_duty(0, 0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL enable cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
      if (first < 0 && pwm_lo[0]) first = j;
    end
    checks++;
    if (first != 5) begin errors++; $display("FAIL enable_lo_delay got %0d want 5", first); end
  endtask

  task automatic test_async_reset;
    setup(0, 9, 1);
    set_duty(0, 5); set_duty(1, 0);
    go();
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      checks++;
      if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
        errors++;
        $display("FAIL async_pre cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({pwm_hi, pwm_lo, period_start} !== '0) begin
      errors++; $display("FAIL async_reset got %b want 0", {pwm_hi, pwm_lo, period_start});
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random;
    int p;
    for (int s = 0; s < 6; s++) begin
      p = $urandom_range(0, 12);
      setup($urandom_range(0, 2), p, $urandom_range(0, 4));
      for (int i = 0; i < CH; i++) set_duty(i, $urandom_range(0, p + 2));
      go();
      for (int j = 1; j <= 80; j++) begin
        @(negedge clk);
        checks++;
        if ({pwm_hi, pwm_lo, period_start} !== {exp_hi, exp_lo, exp_ps()}) begin
          errors++;
          $display("FAIL random seg %0d cyc %0d hi/lo/ps got %b/%b/%b want %b/%b/%b", s, j, pwm_hi, pwm_lo, period_start, exp_hi, exp_lo, exp_ps());
        end
        checks++;
        if ((pwm_hi & pwm_lo) !== '0) begin
          errors++; $display("FAIL overlap seg %0d cyc %0d got %b want 0", s, j, pwm_hi & pwm_lo);
        end
        if ($urandom_range(0, 15) == 0) set_duty($urandom_range(0, CH - 1), $urandom_range(0, p + 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_deadtime();
    test_duty_extremes();
    test_shadow();
    test_prescaler();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
